// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
//   SEG_BLANK  : all segments off (active-low code)
//   NUM_DIGITS : digits on the shared segment bus
//   PHASES     : brightness phases per digit slot
package seg_display_scanner_pkg;

  localparam int             NUM_DIGITS = 4;
  localparam int             PHASES     = 16;
  localparam int             IDX_W      = $clog2(NUM_DIGITS);
  localparam int             PHASE_W    = $clog2(PHASES);
  localparam logic [6:0]     SEG_BLANK  = 7'h7F;
  localparam logic [3:0]     AN_OFF     = 4'hF;

  typedef logic [6:0]         seg_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // Active-low digit enable for one selected digit.
  function automatic logic [NUM_DIGITS-1:0] an_sel(input idx_t idx);
    logic [NUM_DIGITS-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Display bus for the scanner.
//   digit0..digit3 : active-low segment codes, digit0 rightmost (to scanner)
//   freeze         : hold the currently displayed frame          (to scanner)
//   duty           : lit phases out of 16 per digit slot         (to scanner)
//   seg_out        : active-low shared segment bus               (from scanner)
//   an             : active-low digit enables                    (from scanner)
//   frame_tick     : one-cycle pulse after each frame wrap       (from scanner)
interface seg_display_scanner_if;
  import seg_display_scanner_pkg::*;

  seg_t       digit0;
  seg_t       digit1;
  seg_t       digit2;
  seg_t       digit3;
  logic       freeze;
  logic [3:0] duty;
  seg_t       seg_out;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output digit0, digit1, digit2, digit3, freeze, duty,
    input  seg_out, an, frame_tick
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, freeze, duty,
    output seg_out, an, frame_tick
  );

endinterface

// File: rtl/seg_display_scanner_tick.sv
// tick_gen: free-running prescaler, counts 0..DIV-1 and pulses tick_o for
// one cycle while the count sits at DIV-1.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   tick_o : one-cycle tick every DIV cycles
module tick_gen #(
  parameter int DIV = 3125
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed 4-digit 7-segment scanner with PWM brightness.
// Each digit slot is 16 brightness phases of SUB_DIV cycles. A digit is lit
// while phase < duty_q; phase 15 is always dark as an inter-digit blanking
// gap. All four digit codes are captured together at the 3->0 index wrap so
// a frame is always coherent; freeze suppresses that capture.
//   clock : clock
//   reset : synchronous active-high reset
//   bus   : display bus (slave side), see seg_display_scanner_if
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int         SUB_DIV  = 3125,
  parameter logic [3:0] DUTY_RST = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  seg_display_scanner_if.slave  bus
);

  logic phase_tick;
  logic slot_tick;
  logic frame_wrap;
  logic lit;

  phase_t                      phase_q, phase_d;
  idx_t                        idx_q, idx_d;
  logic [3:0]                  duty_q, duty_d;
  logic [NUM_DIGITS-1:0][6:0]  snap_q, snap_d;
  logic [NUM_DIGITS-1:0][6:0]  din;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  seg_t                        seg_q, seg_d;
  logic                        ft_q, ft_d;

  tick_gen #(.DIV(SUB_DIV)) u_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .tick_o (phase_tick)
  );

  assign din = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

  always_comb begin
    slot_tick  = phase_tick && (phase_q == phase_t'(PHASES - 1));
    frame_wrap = slot_tick && (idx_q == idx_t'(NUM_DIGITS - 1));

    phase_d = phase_q;
    idx_d   = idx_q;
    duty_d  = duty_q;
    snap_d  = snap_q;

    if (phase_tick) phase_d = phase_q + 1'b1;
    if (slot_tick) begin
      idx_d  = idx_q + 1'b1;
      duty_d = bus.duty;
    end
    if (frame_wrap && !bus.freeze) snap_d = din;

    // Outputs reflect the current counter state, one cycle later.
    lit   = (phase_q < duty_q) && (phase_q != phase_t'(PHASES - 1));
    an_d  = lit ? an_sel(idx_q) : AN_OFF;
    seg_d = lit ? snap_q[idx_q] : SEG_BLANK;
    ft_d  = frame_wrap;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
      idx_q   <= '0;
      duty_q  <= DUTY_RST;
      snap_q  <= {NUM_DIGITS{SEG_BLANK}};
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      ft_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      duty_q  <= duty_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ft_q    <= ft_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench, SUB_DIV=2: slot = 32 cycles, frame = 128 cycles.
// Edge e counts rising edges after reset release; outputs sampled 1 time
// unit after each edge reflect the counter state after edge e-1.
module tb_seg_display_scanner;

  logic clock = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  seg_display_scanner_if bus();

  seg_display_scanner #(.SUB_DIV(2), .DUTY_RST(4'hF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // At most one digit enable low in any cycle.
  always @(negedge clock)
    if (mon_en) chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);

  initial begin
    int n_blank1 = 0, n_d0 = 0, n_dark = 0, n_d4 = 0, n_lit = 0;
    int n_frz = 0, n_new = 0, n_mid = 0, n_mid2 = 0, n_blank2 = 0;
    logic [3:0] exp_an;

    reset = 1'b1;
    bus.freeze = 1'b0;
    bus.duty   = 4'd15;
    bus.digit0 = 7'h40;
    bus.digit1 = 7'h79;
    bus.digit2 = 7'h24;
    bus.digit3 = 7'h30;
    tick();
    tick();
    chk("rst_an",  bus.an, 4'hF);
    chk("rst_seg", bus.seg_out, 7'h7F);
    chk("rst_ft",  bus.frame_tick, 1'b0);
    mon_en = 1'b1;
    reset  = 1'b0;

    for (int e = 1; e <= 1110; e++) begin
      tick();
      // first frame after release: snapshots still blank
      if (e <= 128 && bus.seg_out != 7'h7F) n_blank1++;
      if (e == 127) chk("ft_127", bus.frame_tick, 1'b0);
      if (e == 128) chk("ft_128", bus.frame_tick, 1'b1);
      if (e == 129) chk("ft_129", bus.frame_tick, 1'b0);
      if (e == 256) chk("ft_256", bus.frame_tick, 1'b1);
      if (e >= 129 && e <= 158 && (bus.an != 4'b1110 || bus.seg_out != 7'h40)) n_d0++;
      if (e == 159) begin chk("gap_an_159", bus.an, 4'hF); chk("gap_seg_159", bus.seg_out, 7'h7F); end
      if (e == 160) begin chk("gap_an_160", bus.an, 4'hF); chk("gap_seg_160", bus.seg_out, 7'h7F); end
      if (e == 161) begin chk("d1_an", bus.an, 4'b1101); chk("d1_seg", bus.seg_out, 7'h79); end
      if (e == 193) begin chk("d2_an", bus.an, 4'b1011); chk("d2_seg", bus.seg_out, 7'h24); end
      if (e == 225) begin chk("d3_an", bus.an, 4'b0111); chk("d3_seg", bus.seg_out, 7'h30); end
      // duty=0 from edge 289; duty=4 requested mid-slot at 400, effective 417
      if (e >= 289 && e <= 416 && bus.an != 4'hF) n_dark++;
      if (e >= 417 && e <= 544) begin
        exp_an = (((e - 1) % 32) < 8) ? ~(4'b0001 << (((e - 1) / 32) % 4)) : 4'hF;
        if (bus.an != exp_an) n_d4++;
        if (bus.an != 4'hF)   n_lit++;
      end
      // freeze across the frame boundary at 640
      if (e == 640) chk("ft_frozen", bus.frame_tick, 1'b1);
      if (e >= 641 && e <= 670 && bus.seg_out != 7'h40) n_frz++;
      if (e >= 769 && e <= 798 && bus.seg_out != 7'h12) n_new++;
      // digit1 changed mid-frame at 780, unfrozen
      if (e >= 801 && e <= 830 && bus.seg_out != 7'h79) n_mid++;
      if (e >= 929 && e <= 958 && bus.seg_out != 7'h02) n_mid2++;
      // reset pulse in the index-2 slot
      if (e == 969) begin chk("pre_rst_an", bus.an, 4'b1011); chk("pre_rst_seg", bus.seg_out, 7'h24); end
      if (e == 970) begin
        chk("mid_rst_an",  bus.an, 4'hF);
        chk("mid_rst_seg", bus.seg_out, 7'h7F);
        chk("mid_rst_ft",  bus.frame_tick, 1'b0);
      end
      if (e >= 971 && e <= 1098 && bus.seg_out != 7'h7F) n_blank2++;
      if (e == 1097) chk("ft2_127", bus.frame_tick, 1'b0);
      if (e == 1098) chk("ft2_128", bus.frame_tick, 1'b1);
      if (e == 1103) begin chk("post_rst_an", bus.an, 4'b1110); chk("post_rst_seg", bus.seg_out, 7'h12); end

      case (e)
        256: bus.duty   = 4'd0;
        400: bus.duty   = 4'd4;
        544: bus.duty   = 4'd15;
        550: bus.freeze = 1'b1;
        560: bus.digit0 = 7'h12;
        700: bus.freeze = 1'b0;
        780: bus.digit1 = 7'h02;
        969: reset      = 1'b1;
        970: reset      = 1'b0;
        default: ;
      endcase
    end

    chk("first_frame_blank", n_blank1, 0);
    chk("d0_30cyc",          n_d0, 0);
    chk("duty0_dark",        n_dark, 0);
    chk("duty4_pattern",     n_d4, 0);
    chk("duty4_lit_count",   n_lit, 32);
    chk("freeze_hold",       n_frz, 0);
    chk("unfreeze_new",      n_new, 0);
    chk("midframe_hold",     n_mid, 0);
    chk("midframe_next",     n_mid2, 0);
    chk("post_rst_blank",    n_blank2, 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 The block SHALL have parameter SUB_DIV, default 3125, giving clock cycles per brightness phase (16 phases per digit slot, so 1 ms per digit at 50 MHz).
REQ-002 The block SHALL have parameter DUTY_RST, default 4'hF, giving the brightness duty loaded at reset.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 digit0..digit3  input  7 each  active-low segment codes (bit set = segment off); digit0 is rightmost.
REQ-006 freeze  input  1  while high, the displayed frame is held.
REQ-007 duty  input  4  brightness; number of lit phases out of 16 in each digit slot.
REQ-008 seg_out  output  7  active-low shared segment bus.
REQ-009 an  output  4  active-low digit enables; at most one bit low at any time.
REQ-010 frame_tick  output  1  one-cycle pulse when the digit index wraps from 3 to 0.

Function
REQ-011 A prescaler SHALL count 0..SUB_DIV-1 and assert an internal phase_tick for one cycle at SUB_DIV-1, then wrap to 0.
REQ-012 A 4-bit phase counter SHALL increment on each phase_tick and wrap from 15 to 0; the wrap event is slot_tick.
REQ-013 A 2-bit digit index SHALL increment on each slot_tick and wrap from 3 to 0.
REQ-014 On the slot_tick that wraps the index 3->0 with freeze=0, all four digit inputs SHALL be captured together into snapshot registers, giving a coherent frame.
REQ-015 With freeze=1 at that slot_tick, the snapshots SHALL be retained; scanning and PWM SHALL continue.
REQ-016 duty SHALL be sampled into duty_reg only on slot_tick, so brightness never changes mid-slot.
REQ-017 Digit enable SHALL be lit when phase < duty_reg: duty_reg=0 gives dark, duty_reg=15 gives 15/16 on-time.
REQ-018 Phase 15 SHALL always be dark, guaranteeing an inter-digit blanking gap for ghost suppression.
REQ-019 an SHALL be registered: an[i]=0 iff i==index and the digit is lit; otherwise an=4'hF.
REQ-020 seg_out SHALL be registered: snapshot[index] when lit, else 7'h7F.
REQ-021 Output latency SHALL be exactly one cycle after the counter state it reflects.
REQ-022 frame_tick SHALL be registered and asserted in the cycle after the 3->0 slot_tick, independent of freeze.
REQ-023 A digit input changing mid-frame SHALL NOT alter seg_out until the next capture.

Reset
REQ-024 On reset=1 at a clock edge, the prescaler, phase and index SHALL clear to 0.
REQ-025 On reset, all snapshots SHALL load 7'h7F, duty_reg SHALL load DUTY_RST, an SHALL be 4'hF, seg_out SHALL be 7'h7F, and frame_tick SHALL be 0.
REQ-026 Reset asserted mid-slot SHALL abort the slot; the display SHALL stay blank until the first 3->0 capture after release, which occurs 64*SUB_DIV cycles after release.
REQ-027 Reset SHALL override freeze.

Structure
REQ-028 A shared package SHALL hold SEG_BLANK (7'h7F), NUM_DIGITS (4) and PHASES (16).
REQ-029 The prescaler SHALL be a sub-module tick_gen, parameterised by its division ratio and producing a one-cycle tick.
REQ-030 The remaining logic (phase, index, snapshots, output registers) SHALL be flat within seg_display_scanner.

Verification (SUB_DIV=2: slot = 32 cycles, frame = 128 cycles)
REQ-031 Reset, then digits 7'h40/7'h79/7'h24/7'h30 with duty=15 -> first frame blank; frame_tick at cycle 128. The next frame shows an=1110 with seg_out=7'h40 for 30 cycles, then dark for 2 cycles, then an=1101 with seg_out=7'h79, and so on.
REQ-032 Duty sweep: duty=0 -> an stays 4'hF permanently; duty=4 -> each digit lit for exactly 8 cycles per 32-cycle slot.
REQ-033 duty changed mid-slot -> on-time changes only from the next slot boundary.
REQ-034 freeze=1 before a frame boundary, then digit0 changed to 7'h12 -> seg_out for digit0 keeps the old code. After freeze=0, the new code appears from the next frame.
REQ-035 Reset pulsed mid-slot at index 2 -> next cycle an=4'hF and seg_out=7'h7F; the display stays blank until the first capture after release. The bench SHALL check that an never has two low bits in any cycle.
